// File: rtl/adder_pkg.sv
// Shared definitions for the registered ripple-carry adder: default width and
// a reference model of the exact (a+b) mod 2^n sum with its carry-out.
package adder_pkg;

    localparam int ADDER_N_DEFAULT = 18;

    // Widest operand the reference model can handle.
    localparam int ADDER_N_MAX = 64;

    typedef struct packed {
        logic                   carry;
        logic [ADDER_N_MAX-1:0] sum;
    } adder_result_t;

    // Operands are truncated to n bits; the carry is bit n of the exact sum.
    function automatic adder_result_t adder_model(
        input logic [ADDER_N_MAX-1:0] a,
        input logic [ADDER_N_MAX-1:0] b,
        input int                     n
    );
        logic [ADDER_N_MAX:0]   full;
        logic [ADDER_N_MAX-1:0] mask;
        adder_result_t          r;
        mask = '1;
        if (n < ADDER_N_MAX) begin
            mask = mask >> (ADDER_N_MAX - n);
        end
        full    = {1'b0, a & mask} + {1'b0, b & mask};
        r.sum   = full[ADDER_N_MAX-1:0] & mask;
        r.carry = full[n[6:0]];
        return r;
    endfunction

endpackage

// File: rtl/adder_if.sv
// Operand/result bundle of the adder: the harness drives the operands as
// master, the adder returns the registered sum and carry as slave.
interface adder_if
    import adder_pkg::*;
#(
    parameter int N = ADDER_N_DEFAULT
) ();

    logic [N-1:0] input1;
    logic [N-1:0] input2;
    logic [N-1:0] sum;
    logic         carry_out;

    modport master (
        output input1,
        output input2,
        input  sum,
        input  carry_out
    );

    modport slave (
        input  input1,
        input  input2,
        output sum,
        output carry_out
    );

endinterface

// File: rtl/full_adder_cell.sv
// One-bit full adder; chained by adder_unit into an explicit ripple so that
// switching activity looks like a gate-level carry chain.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/adder_unit.sv
// Registered N-bit unsigned adder built from a ripple of full_adder_cell
// instances; sum and carry-out are captured every rising edge.
module adder_unit
    import adder_pkg::*;
#(
    parameter int N = ADDER_N_DEFAULT
) (
    input logic   clk,
    input logic   rst,
    adder_if.slave bus
);

    generate
        if (N < 1) begin : g_bad_width
            $error("adder_unit: N must be at least 1");
        end
    endgenerate

    logic [N:0]   carry;
    logic [N-1:0] sum_comb;
    logic [N-1:0] sum_q;
    logic         carry_q;

    assign carry[0] = 1'b0;

    // No '+' here: the chain must stay a visible ripple for characterization.
    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_ripple
            full_adder_cell u_fa (
                .a    (bus.input1[i]),
                .b    (bus.input2[i]),
                .cin  (carry[i]),
                .s    (sum_comb[i]),
                .cout (carry[i+1])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            sum_q   <= sum_comb;
            carry_q <= carry[N];
        end
    end

    assign bus.sum       = sum_q;
    assign bus.carry_out = carry_q;

endmodule

// File: tb/tb_adder_unit.sv
// Directed and streaming checks of adder_unit at the default 18-bit width,
// including async reset both at start-up and in the middle of a stream.
module tb_adder_unit;
    import adder_pkg::*;

    localparam int W = 18;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    adder_if #(.N(W)) bus ();

    adder_unit #(.N(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Operands change on the falling edge so they are stable at capture.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        bus.input1 = a;
        bus.input2 = b;
    endtask

    task automatic checkOutput(input string tag, input logic [W-1:0] exp_sum, input logic exp_carry);
        checks++;
        assert (bus.sum === exp_sum) else begin
            errors++;
            $error("[TB] FAIL %s sum: got %h expected %h", tag, bus.sum, exp_sum);
        end
        checks++;
        assert (bus.carry_out === exp_carry) else begin
            errors++;
            $error("[TB] FAIL %s carry_out: got %b expected %b", tag, bus.carry_out, exp_carry);
        end
    endtask

    task automatic stepAndCheck(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] exp_sum, input logic exp_carry);
        applyStimulus(a, b);
        @(posedge clk);
        #1;
        checkOutput(tag, exp_sum, exp_carry);
    endtask

    task automatic modelCheck(input string tag);
        adder_result_t r;
        r = adder_model(ADDER_N_MAX'(bus.input1), ADDER_N_MAX'(bus.input2), W);
        checkOutput(tag, r.sum[W-1:0], r.carry);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [35:0] words [9];
        logic [35:0] w;

        checks = 0;
        errors = 0;
        words[0] = 36'hFF0000000;
        words[1] = 36'hFFFF00000;
        words[2] = 36'hFFFFFF000;
        words[3] = 36'hFFFFFFFF0;
        words[4] = 36'h0FFFFFFFF;
        words[5] = 36'h000FFFFFF;
        words[6] = 36'h00000FFFF;
        words[7] = 36'h0000000FF;
        words[8] = 36'h000000000;

        $display("[TB] reset behaviour");
        rst        = 1'b1;
        bus.input1 = 18'h3FFFF;
        bus.input2 = 18'h3FFFF;
        #2;
        checkOutput("reset_immediate", 18'h00000, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("reset_hold", 18'h00000, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset_release", 18'h3FFFE, 1'b1);

        $display("[TB] directed vectors");
        stepAndCheck("zero_plus_3fc00", 18'h00000, 18'h3FC00, 18'h3FC00, 1'b0);
        stepAndCheck("zero_plus_3fffc", 18'h00000, 18'h3FFFC, 18'h3FFFC, 1'b0);
        stepAndCheck("wrap",            18'h3F000, 18'h3FFFF, 18'h3EFFF, 1'b1);
        stepAndCheck("full_ripple",     18'h3FFFF, 18'h00001, 18'h00000, 1'b1);
        stepAndCheck("msb_carry",       18'h20000, 18'h20000, 18'h00000, 1'b1);
        stepAndCheck("small_sum",       18'h00005, 18'h0000A, 18'h0000F, 1'b0);
        stepAndCheck("alt_bits",        18'h2AAAA, 18'h15555, 18'h3FFFF, 1'b0);

        $display("[TB] streaming pattern");
        for (int pkt = 0; pkt < 10; pkt++) begin
            for (int k = 0; k < 27; k++) begin
                if (k < 20) begin
                    w = words[k % 9];
                end else begin
                    w = '0;
                end
                applyStimulus(w[17:0], w[35:18]);
                @(posedge clk);
                #1;
                modelCheck("stream");
                if (pkt == 4 && k == 10) begin
                    // Reset lands between edges; the next capture must not see stale data.
                    #2;
                    rst = 1'b1;
                    #1;
                    checkOutput("midstream_reset_immediate", 18'h00000, 1'b0);
                    @(posedge clk);
                    #1;
                    checkOutput("midstream_reset_hold", 18'h00000, 1'b0);
                    @(negedge clk);
                    rst        = 1'b0;
                    bus.input1 = 18'h12345;
                    bus.input2 = 18'h3ABCD;
                    @(posedge clk);
                    #1;
                    checkOutput("midstream_resume", 18'h0CF12, 1'b1);
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adder_unit.md
# adder_unit

Registered N-bit unsigned adder used as the characterization target for adder switching-energy estimation. Two N-bit operands are summed modulo 2^N; the result and carry-out are captured on the rising clock edge. The carry chain is an explicit ripple of full-adder cells, so toggle activity is representative of a gate-level adder. The block sits standalone under an energy/VCD-dump harness that drives patterned operands every clock.

## Interface
- N, default 18: operand and sum width in bits; legal range is N ≥ 1.
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous and active-high.
- input1  input  N  operand A, unsigned.
- input2  input  N  operand B, unsigned.
- sum  output  N  registered (input1 + input2) mod 2^N.
- carry_out  output  1  registered carry out of bit N-1.

## Operation
- Combinational core computes {c, s} = input1 + input2 with N+1-bit exact arithmetic.
  - s is bits N-1..0.
  - c is bit N.
- Unsigned only. No signed overflow flag. No saturation; wrap-around is the defined behaviour.
- Carry chain:
  - Carry-in of bit 0 is constant 0.
  - Bit i uses a full adder on input1[i], input2[i] and carry[i].
  - carry[N] drives carry_out.
- Outputs are registered every cycle; there is no enable and no handshake.
- X or Z on an operand propagates to the affected sum bits. No masking.

## Timing
- Latency is 1 cycle. Operands sampled at rising edge k appear on sum/carry_out after edge k and hold until edge k+1.
- Throughput is one result per cycle.
- Reset:
  - rst high forces sum = 0 and carry_out = 0 immediately, independent of clk.
  - Outputs hold 0 while rst is high.
  - The first edge after rst deasserts captures the current operands.
- Reset mid-stream discards any in-flight result. No recovery state exists.
- Operand changes between edges have no effect until the next edge. Output flops must not glitch.

## Structure
- Shared package adder_pkg:
  - ADDER_N_DEFAULT = 18.
  - Function for the reference model, (a+b) mod 2^N plus carry, for bench use.
- Sub-module full_adder_cell, instantiated N times by generate:
  - Inputs a, b, cin.
  - Outputs s = a^b^cin and cout = (a&b)|(cin&(a^b)).
- Top level holds:
  - The generate loop.
  - The N+1 output register with async reset.
  - A parameter check that N ≥ 1 and errors at elaboration otherwise.
- No behavioural "+" in the datapath. The ripple structure is mandatory for characterization fidelity.

## Test plan
- Reset check: drive rst=1 with input1=0x3FFFF and input2=0x3FFFF -> sum=0x00000 and carry_out=0 immediately. Release rst -> next edge gives sum=0x3FFFE, carry_out=1.
- Zero-plus-operand: input1=0x00000, input2=0x3FC00 -> one cycle later sum=0x3FC00, carry_out=0. Repeat with input2=0x3FFFC -> sum=0x3FFFC.
- Wrap case: input1=0x3F000, input2=0x3FFFF -> sum=0x3EFFF, carry_out=1.
- Full carry propagation: input1=0x3FFFF, input2=0x00001 -> sum=0x00000, carry_out=1. Then input1=0x20000, input2=0x20000 -> sum=0x00000, carry_out=1.
- Streaming pattern: run a 36-bit walking-ones word sequence for 20 back-to-back cycles, then 7 idle cycles, repeated for 10 packets.
  - The sequence is 0xFF0000000 → 0xFFFF00000 → 0xFFFFFF000 → 0xFFFFFFFF0 → 0x0FFFFFFFF → 0x000FFFFFF → 0x00000FFFF → 0x0000000FF → 0.
  - Split each word as input1 = bits 17..0 and input2 = bits 35..18.
  - Every cycle's output must equal the adder_pkg model of the previous cycle's operands.
- Async reset mid-stream: assert rst between edges during the streaming pattern -> outputs go to 0 before the next edge. After release, resumed results match the model with no stale value.
